// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - signal bundle between the MIPS datapath and the hazard controller
//
// master : datapath side (drives pipeline register fields, consumes hazard controls)
// slave  : hazard controller side
// Pipeline fields : id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_memread,
//                   ex_redirect, mem_rd, mem_regw, wb_rd, wb_regw
// Hazard controls : A_src, B_src, pc_write, ifid_write, ifid_flush, idex_bubble,
//                   stall_cnt, flush_cnt (CNT_W wide)
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rs;
   logic [4:0]       ex_rt;
   logic [4:0]       ex_rd;
   logic             ex_memread;
   logic             ex_redirect;
   logic [4:0]       mem_rd;
   logic             mem_regw;
   logic [4:0]       wb_rd;
   logic             wb_regw;
   logic [1:0]       A_src;
   logic [1:0]       B_src;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_memread, ex_redirect,
             mem_rd, mem_regw, wb_rd, wb_regw,
      input  A_src, B_src, pc_write, ifid_write, ifid_flush, idex_bubble,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_memread, ex_redirect,
             mem_rd, mem_regw, wb_rd, wb_regw,
      output A_src, B_src, pc_write, ifid_write, ifid_flush, idex_bubble,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use stall and redirect flush control for the 5-stage MIPS pipe
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-low; while low the pipe is frozen and flushed
//   hz  : pipe_hazard_ctrl_if.slave bundle (pipeline fields in, hazard controls out)
// Parameters:
//   STALL_CYC : cycles PC/IF-ID are frozen per load-use hazard (>=1)
//   FLUSH_CYC : cycles ifid_flush/idex_bubble are held after a redirect (>=1)
//   CNT_W     : performance counter width
// Optional feature macro: HAZ_PERF_CNT_EN (saturating stall/flush counters; tied to 0 otherwise)
module pipe_hazard_ctrl #(
   parameter int STALL_CYC = 1,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int MAX_CYC = (STALL_CYC > FLUSH_CYC) ? STALL_CYC : FLUSH_CYC;
   // cnt holds at most MAX_CYC-1
   localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lu;
   logic          pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]    a_src, b_src;

   // Forwarding: EX/MEM result is younger than WB, so it takes priority; $0 never forwarded.
   always_comb begin
      a_src = 2'b00;
      b_src = 2'b00;
      if (hz.mem_regw && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs)
         a_src = 2'b01;
      else if (hz.wb_regw && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs)
         a_src = 2'b10;
      if (hz.mem_regw && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rt)
         b_src = 2'b01;
      else if (hz.wb_regw && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rt)
         b_src = 2'b10;
      if (!rst) begin
         a_src = 2'b00;
         b_src = 2'b00;
      end
   end

   assign lu = hz.ex_memread && hz.ex_rd != 5'd0 &&
               (hz.ex_rd == hz.id_rs || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      case (state_q)
         RUN, STALL: begin
            // A redirect squashes the stalled instruction, so it overrides both a new
            // load-use hit and an in-progress stall.
            if (hz.ex_redirect) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (FLUSH_CYC > 1) begin
                  state_d = FLUSH;
                  cnt_d   = CW'(FLUSH_CYC - 1);
               end else begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end else if (state_q == STALL) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               cnt_d       = cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_d = RUN;
            end else if (lu) begin
               // The detecting cycle is itself the first stall cycle.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (STALL_CYC > 1) begin
                  state_d = STALL;
                  cnt_d   = CW'(STALL_CYC - 1);
               end
            end
         end
         FLUSH: begin
            // ID holds a squashed NOP, so a load-use match here is spurious.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = RUN;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   assign hz.A_src       = a_src;
   assign hz.B_src       = b_src;
   assign hz.pc_write    = pc_write;
   assign hz.ifid_write  = ifid_write;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_evt, flush_evt;

   // pc_write is only ever low outside reset for a load-use stall.
   assign stall_evt = rst && !pc_write;
   assign flush_evt = rst && hz.ex_redirect && (state_q != FLUSH);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt && flush_cnt_q != {CNT_W{1'b1}})
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   pipe_hazard_ctrl_if #(.CNT_W(16)) h0 ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  h1 ();

   pipe_hazard_ctrl #(.STALL_CYC(1), .FLUSH_CYC(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .hz(h0));
   pipe_hazard_ctrl #(.STALL_CYC(3), .FLUSH_CYC(2), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .hz(h1));

   // {A_src, B_src, pc_write, ifid_write, ifid_flush, idex_bubble}
   logic [7:0] o0, o1;
   assign o0 = {h0.A_src, h0.B_src, h0.pc_write, h0.ifid_write, h0.ifid_flush, h0.idex_bubble};
   assign o1 = {h1.A_src, h1.B_src, h1.pc_write, h1.ifid_write, h1.ifid_flush, h1.idex_bubble};

   typedef struct {
      logic [4:0] id_rs, id_rt;
      logic       id_uses_rt;
      logic [4:0] ex_rs, ex_rt, ex_rd;
      logic       ex_memread, ex_redirect;
      logic [4:0] mem_rd;
      logic       mem_regw;
      logic [4:0] wb_rd;
      logic       wb_regw;
      logic [7:0] exp;
   } vec_t;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vt[15];

   function automatic vec_t mk(input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                               input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                               input logic mr, input logic rdr, input logic [4:0] mrd,
                               input logic mw, input logic [4:0] wrd, input logic ww,
                               input logic [7:0] e);
      vec_t v;
      v.id_rs = irs; v.id_rt = irt; v.id_uses_rt = urt;
      v.ex_rs = ers; v.ex_rt = ert; v.ex_rd = erd;
      v.ex_memread = mr; v.ex_redirect = rdr;
      v.mem_rd = mrd; v.mem_regw = mw; v.wb_rd = wrd; v.wb_regw = ww;
      v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive0(input vec_t v);
      h0.id_rs = v.id_rs; h0.id_rt = v.id_rt; h0.id_uses_rt = v.id_uses_rt;
      h0.ex_rs = v.ex_rs; h0.ex_rt = v.ex_rt; h0.ex_rd = v.ex_rd;
      h0.ex_memread = v.ex_memread; h0.ex_redirect = v.ex_redirect;
      h0.mem_rd = v.mem_rd; h0.mem_regw = v.mem_regw;
      h0.wb_rd = v.wb_rd; h0.wb_regw = v.wb_regw;
   endtask

   // dut1 stimulus: optional load-use hit on $2 and optional redirect, no forwarding
   task automatic set1(input logic lu_on, input logic rdr);
      h1.id_rs = lu_on ? 5'd2 : 5'd0; h1.id_rt = 5'd0; h1.id_uses_rt = 1'b0;
      h1.ex_rs = 5'd0; h1.ex_rt = 5'd0; h1.ex_rd = lu_on ? 5'd2 : 5'd0;
      h1.ex_memread = lu_on; h1.ex_redirect = rdr;
      h1.mem_rd = 5'd0; h1.mem_regw = 1'b0; h1.wb_rd = 5'd0; h1.wb_regw = 1'b0;
   endtask

   // inputs are set just after a rising edge; check at the falling edge, then advance
   task automatic cyc1(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk(nm, {24'b0, o1}, {24'b0, exp});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = mk(0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0,  8'b00_00_1100);
      vt[1]  = mk(0, 0, 0,  3, 5, 4,  0, 0,  3, 1,  0, 0,  8'b01_00_1100);
      vt[2]  = mk(0, 0, 0,  7, 7, 1,  0, 0,  7, 1,  7, 1,  8'b01_01_1100);
      vt[3]  = mk(0, 0, 0,  2, 2, 4,  0, 0,  9, 1,  2, 1,  8'b10_10_1100);
      vt[4]  = mk(0, 0, 0,  0, 0, 0,  0, 0,  0, 1,  0, 1,  8'b00_00_1100);
      vt[5]  = mk(0, 0, 0,  4, 6, 1,  0, 0,  4, 0,  4, 1,  8'b10_00_1100);
      vt[6]  = mk(2, 3, 0,  0, 0, 2,  1, 0,  0, 0,  0, 0,  8'b00_00_0001);
      vt[7]  = mk(1, 2, 1,  0, 0, 2,  1, 0,  0, 0,  0, 0,  8'b00_00_0001);
      vt[8]  = mk(1, 2, 0,  0, 0, 2,  1, 0,  0, 0,  0, 0,  8'b00_00_1100);
      vt[9]  = mk(0, 0, 1,  0, 0, 0,  1, 0,  0, 0,  0, 0,  8'b00_00_1100);
      vt[10] = mk(5, 0, 0,  0, 0, 5,  0, 0,  0, 0,  0, 0,  8'b00_00_1100);
      vt[11] = mk(0, 0, 0,  0, 0, 0,  0, 1,  0, 0,  0, 0,  8'b00_00_1111);
      vt[12] = mk(2, 0, 0,  0, 0, 2,  1, 1,  0, 0,  0, 0,  8'b00_00_1111);
      vt[13] = mk(8, 0, 0,  0, 8, 8,  1, 0,  0, 0,  8, 1,  8'b00_10_0001);
      vt[14] = mk(0, 0, 0,  1, 6, 3,  0, 0,  6, 1,  6, 1,  8'b00_01_1100);

      drive0(vt[0]);
      set1(1'b0, 1'b0);
      h0.mem_rd = 5'd3; h0.mem_regw = 1'b1; h0.ex_rs = 5'd3;

      // reset state: controls forced, forwarding suppressed
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("reset_out0", {24'b0, o0}, {24'b0, 8'b00_00_0011});
      chk("reset_out1", {24'b0, o1}, {24'b0, 8'b00_00_0011});
      chk("reset_stall_cnt", {30'b0, h1.stall_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // single-cycle events on the default-parameter instance
      for (int i = 0; i < 15; i++) begin
         drive0(vt[i]);
         @(negedge clk);
         chk($sformatf("vec%0d", i), {24'b0, o0}, {24'b0, vt[i].exp});
         @(posedge clk);
         #1;
      end
      drive0(vt[0]);
      @(negedge clk);
      chk("u0_stall_cnt", {16'b0, h0.stall_cnt}, PERF ? 32'd3 : 32'd0);
      chk("u0_flush_cnt", {16'b0, h0.flush_cnt}, PERF ? 32'd2 : 32'd0);
      @(posedge clk);
      #1;

      // load-use with STALL_CYC=3: three frozen cycles, then run
      set1(1'b1, 1'b0); cyc1("lu_c0", 8'b00_00_0001);
      set1(1'b0, 1'b0); cyc1("lu_c1", 8'b00_00_0001);
      cyc1("lu_c2", 8'b00_00_0001);
      cyc1("lu_run", 8'b00_00_1100);

      // redirect with FLUSH_CYC=2; load-use during FLUSH is ignored
      set1(1'b0, 1'b1); cyc1("rd_c0", 8'b00_00_1111);
      set1(1'b1, 1'b0); cyc1("rd_c1_lu_ign", 8'b00_00_1111);
      set1(1'b0, 1'b0); cyc1("rd_run", 8'b00_00_1100);

      // redirect arriving during STALL aborts the stall
      set1(1'b1, 1'b0); cyc1("ab_lu", 8'b00_00_0001);
      set1(1'b1, 1'b1); cyc1("ab_redirect", 8'b00_00_1111);
      set1(1'b0, 1'b0); cyc1("ab_flush", 8'b00_00_1111);
      cyc1("ab_run", 8'b00_00_1100);

      // reset on the second stall cycle abandons the sequence
      set1(1'b1, 1'b0); cyc1("rs_lu", 8'b00_00_0001);
      set1(1'b0, 1'b0);
      rst = 1'b0;
      h1.mem_rd = 5'd3; h1.mem_regw = 1'b1; h1.ex_rs = 5'd3;
      cyc1("rs_forced", 8'b00_00_0011);
      rst = 1'b1;
      set1(1'b0, 1'b0);
      @(negedge clk);
      chk("rs_stall_cnt", {30'b0, h1.stall_cnt}, 32'd0);
      chk("rs_flush_cnt", {30'b0, h1.flush_cnt}, 32'd0);
      @(posedge clk);
      #1;
      cyc1("rs_run", 8'b00_00_1100);
      cyc1("rs_run2", 8'b00_00_1100);

      // simultaneous redirect and load-use: redirect wins, no stall counted
      set1(1'b1, 1'b1); cyc1("rl_c0", 8'b00_00_1111);
      set1(1'b0, 1'b0); cyc1("rl_c1", 8'b00_00_1111);
      cyc1("rl_run", 8'b00_00_1100);
      @(negedge clk);
      chk("rl_stall_cnt", {30'b0, h1.stall_cnt}, 32'd0);
      chk("rl_flush_cnt", {30'b0, h1.flush_cnt}, PERF ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;

      // two load-use events = 6 stall cycles; CNT_W=2 counter saturates at 3
      for (int k = 0; k < 2; k++) begin
         set1(1'b1, 1'b0); cyc1("sat_lu", 8'b00_00_0001);
         set1(1'b0, 1'b0); cyc1("sat_s1", 8'b00_00_0001);
         cyc1("sat_s2", 8'b00_00_0001);
      end
      @(negedge clk);
      chk("sat_stall_cnt", {30'b0, h1.stall_cnt}, PERF ? 32'd3 : 32'd0);
      @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
